// File: rtl/sram_pkg.sv
// sram_pkg: shared types, width helpers and default geometry for the SRAM port arbiter
package sram_pkg;
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int v = n; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  typedef enum logic {OWN_CPU, OWN_LD} owner_t;
  typedef enum logic {ST_IDLE, ST_RESP} state_t;
  localparam int DEF_NB_COL = 4;
  localparam int DEF_COL_WIDTH = 8;
  localparam int DEF_RAM_DEPTH = 8192;
  localparam int DEF_DW = DEF_NB_COL * DEF_COL_WIDTH;
  localparam int DEF_AW = clogb2(DEF_RAM_DEPTH - 1);
endpackage

// File: rtl/sram_addr_decode.sv
// sram_addr_decode: CPU byte address to SRAM word index plus window range check
module sram_addr_decode
  import sram_pkg::*;
#(
  parameter int NB_COL = DEF_NB_COL,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int AW = clogb2(RAM_DEPTH - 1)
) (
  input  logic [31:0]   cpu_addr,
  output logic [AW-1:0] word,
  output logic          in_range
);
  localparam int LB = clogb2(NB_COL - 1);
  // 33-bit span so a window ending at 4 GiB does not wrap
  localparam logic [32:0] SPAN = 33'(RAM_DEPTH) * 33'(NB_COL);
  logic [31:0] off;
  assign off = cpu_addr - BASE_ADDR;
  assign in_range = (cpu_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign word = AW'(off >> LB);
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: CPU/loader arbitration onto a single-port byte-write SRAM, loader has priority
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int NB_COL = DEF_NB_COL,
  parameter int COL_WIDTH = DEF_COL_WIDTH,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int DW = NB_COL * COL_WIDTH,
  localparam int AW = clogb2(RAM_DEPTH - 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [31:0]       cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  input  logic [NB_COL-1:0] cpu_wstrb,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_err,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_wdata,
  input  logic [NB_COL-1:0] ld_wstrb,
  output logic [DW-1:0]     ld_rdata,
  input  logic              ld_lock,
  output logic              sram_en,
  output logic [NB_COL-1:0] sram_we,
  output logic [AW-1:0]     sram_addr,
  output logic [DW-1:0]     sram_wdata,
  input  logic [DW-1:0]     sram_rdata
);
  state_t st;
  owner_t own;
  logic rd, err;
  logic ld_gnt, cpu_gnt, act, in_range;
  logic [AW-1:0] cpu_word;
  sram_addr_decode #(
    .NB_COL(NB_COL),
    .RAM_DEPTH(RAM_DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_dec (
    .cpu_addr(cpu_addr),
    .word(cpu_word),
    .in_range(in_range)
  );
  // resetn gates the combinational SRAM drive so nothing leaks out during reset
  assign ld_gnt = resetn && st == ST_IDLE && ld_valid;
  assign cpu_gnt = resetn && st == ST_IDLE && !ld_valid && cpu_valid && !ld_lock;
  assign act = ld_gnt || (cpu_gnt && in_range);
  always_comb begin
    sram_en = act;
    sram_we = act ? (ld_gnt ? ld_wstrb : cpu_wstrb) : '0;
    sram_addr = act ? (ld_gnt ? ld_addr : cpu_word) : '0;
    sram_wdata = act ? (ld_gnt ? ld_wdata : cpu_wdata) : '0;
    cpu_ready = st == ST_RESP && own == OWN_CPU;
    ld_ready = st == ST_RESP && own == OWN_LD;
    cpu_rdata = (cpu_ready && rd && !err) ? sram_rdata : '0;
    ld_rdata = (ld_ready && rd) ? sram_rdata : '0;
    cpu_err = cpu_ready && err;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st <= ST_IDLE;
      own <= OWN_CPU;
      rd <= 1'b0;
      err <= 1'b0;
    end else if (st == ST_RESP) begin
      st <= ST_IDLE;
    end else if (ld_gnt || cpu_gnt) begin
      st <= ST_RESP;
      own <= ld_gnt ? OWN_LD : OWN_CPU;
      rd <= ld_gnt ? ~|ld_wstrb : ~|cpu_wstrb;
      err <= cpu_gnt && !in_range;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of the arbiter against a write-first byte-write SRAM model
module tb_sram_port_arbiter;
  import sram_pkg::*;
  localparam int NB_COL = 4;
  localparam int COL_WIDTH = 8;
  localparam int RAM_DEPTH = 8192;
  localparam int DW = 32;
  localparam int AW = 13;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic clk, resetn;
  logic cpu_valid, cpu_ready, cpu_err;
  logic [31:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic [NB_COL-1:0] cpu_wstrb;
  logic ld_valid, ld_ready, ld_lock;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic [NB_COL-1:0] ld_wstrb;
  logic sram_en;
  logic [NB_COL-1:0] sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  int errors = 0;
  int checks = 0;
  sram_port_arbiter #(
    .NB_COL(NB_COL),
    .COL_WIDTH(COL_WIDTH),
    .RAM_DEPTH(RAM_DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_wstrb(ld_wstrb), .ld_rdata(ld_rdata), .ld_lock(ld_lock),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [DW-1:0] mem [RAM_DEPTH];
  logic [DW-1:0] merged;
  always_comb begin
    merged = mem[sram_addr];
    for (int b = 0; b < NB_COL; b++)
      if (sram_we[b]) merged[b*COL_WIDTH +: COL_WIDTH] = sram_wdata[b*COL_WIDTH +: COL_WIDTH];
  end
  always @(posedge clk) begin
    if (sram_en) mem[sram_addr] <= merged;
    sram_rdata <= sram_en ? merged : '0;
  end
  task automatic cyc;
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 32'({cpu_ready, ld_ready, cpu_err, sram_en, sram_we}), 32'h0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_ld_rdata"}, ld_rdata, 32'h0);
    chk({tag, "_sram_addr"}, 32'(sram_addr), 32'h0);
    chk({tag, "_sram_wdata"}, sram_wdata, 32'h0);
  endtask
  initial begin
    resetn = 1'b0;
    cpu_valid = 1'b1;
    cpu_addr = BASE + 32'h10;
    cpu_wdata = 32'hDEAD_BEEF;
    cpu_wstrb = 4'hF;
    ld_valid = 1'b0;
    ld_addr = '0;
    ld_wdata = '0;
    ld_wstrb = '0;
    ld_lock = 1'b0;
    cyc;
    chk_zero("reset_valid_high");
    cpu_valid = 1'b0;
    resetn = 1'b1;
    cyc;
    chk_zero("idle_after_reset");
    cpu_valid = 1'b1;
    #1;
    chk("wr_en", 32'(sram_en), 32'h1);
    chk("wr_we", 32'(sram_we), 32'hF);
    chk("wr_addr", 32'(sram_addr), 32'h4);
    chk("wr_wdata", sram_wdata, 32'hDEAD_BEEF);
    chk("wr_no_early_ready", 32'(cpu_ready), 32'h0);
    cyc;
    chk("wr_ready", 32'(cpu_ready), 32'h1);
    chk("wr_err", 32'(cpu_err), 32'h0);
    chk("wr_rdata_zero", cpu_rdata, 32'h0);
    chk("wr_resp_en_low", 32'(sram_en), 32'h0);
    chk("wr_ld_ready_low", 32'(ld_ready), 32'h0);
    cpu_wstrb = 4'h0;
    cyc;
    chk("rd_en", 32'(sram_en), 32'h1);
    chk("rd_we", 32'(sram_we), 32'h0);
    chk("rd_addr", 32'(sram_addr), 32'h4);
    cyc;
    chk("rd_ready", 32'(cpu_ready), 32'h1);
    chk("rd_data", cpu_rdata, 32'hDEAD_BEEF);
    cpu_wdata = 32'h0000_AA00;
    cpu_wstrb = 4'b0010;
    cyc;
    chk("bwr_we", 32'(sram_we), 32'h2);
    chk("bwr_wdata", sram_wdata, 32'h0000_AA00);
    cyc;
    chk("bwr_ready", 32'(cpu_ready), 32'h1);
    cpu_wstrb = 4'h0;
    cyc;
    cyc;
    chk("bwr_rd_data", cpu_rdata, 32'hDEAD_AAEF);
    cpu_valid = 1'b0;
    cyc;
    ld_valid = 1'b1;
    ld_addr = 13'd7;
    ld_wdata = 32'h1234_5678;
    ld_wstrb = 4'hF;
    cpu_valid = 1'b1;
    cpu_addr = BASE + 32'h1C;
    cpu_wstrb = 4'h0;
    #1;
    chk("prio_addr", 32'(sram_addr), 32'h7);
    chk("prio_we", 32'(sram_we), 32'hF);
    chk("prio_wdata", sram_wdata, 32'h1234_5678);
    cyc;
    chk("prio_ld_ready", 32'(ld_ready), 32'h1);
    chk("prio_cpu_wait", 32'(cpu_ready), 32'h0);
    chk("prio_ld_rdata", ld_rdata, 32'h0);
    ld_valid = 1'b0;
    cyc;
    chk("prio_cpu_en", 32'(sram_en), 32'h1);
    chk("prio_cpu_addr", 32'(sram_addr), 32'h7);
    cyc;
    chk("prio_cpu_ready", 32'(cpu_ready), 32'h1);
    chk("prio_ld_idle", 32'(ld_ready), 32'h0);
    chk("prio_cpu_rdata", cpu_rdata, 32'h1234_5678);
    cpu_valid = 1'b0;
    cyc;
    ld_valid = 1'b1;
    ld_wstrb = 4'h0;
    #1;
    chk("ldrd_en", 32'(sram_en), 32'h1);
    cyc;
    chk("ldrd_ready", 32'(ld_ready), 32'h1);
    chk("ldrd_data", ld_rdata, 32'h1234_5678);
    chk("ldrd_cpu_rdata", cpu_rdata, 32'h0);
    ld_valid = 1'b0;
    cyc;
    cpu_valid = 1'b1;
    cpu_addr = BASE + 32'h8000;
    cpu_wstrb = 4'h0;
    #1;
    chk("oor_hi_en", 32'(sram_en), 32'h0);
    chk("oor_hi_we", 32'(sram_we), 32'h0);
    cyc;
    chk("oor_hi_ready", 32'(cpu_ready), 32'h1);
    chk("oor_hi_err", 32'(cpu_err), 32'h1);
    chk("oor_hi_rdata", cpu_rdata, 32'h0);
    cpu_addr = BASE - 32'h4;
    cyc;
    chk("oor_lo_en", 32'(sram_en), 32'h0);
    cyc;
    chk("oor_lo_err", 32'(cpu_err), 32'h1);
    cpu_addr = BASE + 32'h8010;
    cpu_wstrb = 4'hF;
    cpu_wdata = 32'hFFFF_FFFF;
    cyc;
    chk("oor_wr_en", 32'(sram_en), 32'h0);
    cyc;
    chk("oor_wr_err", 32'(cpu_err), 32'h1);
    cpu_addr = BASE + 32'h10;
    cpu_wstrb = 4'h0;
    cyc;
    chk("oor_chk_addr", 32'(sram_addr), 32'h4);
    cyc;
    chk("oor_untouched", cpu_rdata, 32'hDEAD_AAEF);
    chk("oor_chk_err", 32'(cpu_err), 32'h0);
    cpu_addr = BASE + 32'h7FFC;
    cpu_wstrb = 4'hF;
    cpu_wdata = 32'hCAFE_F00D;
    cyc;
    chk("top_en", 32'(sram_en), 32'h1);
    chk("top_addr", 32'(sram_addr), 32'h1FFF);
    cyc;
    chk("top_err", 32'(cpu_err), 32'h0);
    cpu_wstrb = 4'h0;
    cyc;
    cyc;
    chk("top_rdata", cpu_rdata, 32'hCAFE_F00D);
    cpu_valid = 1'b0;
    cyc;
    ld_lock = 1'b1;
    cpu_valid = 1'b1;
    cpu_addr = BASE + 32'h10;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("lock_en", 32'(sram_en), 32'h0);
      chk("lock_ready", 32'(cpu_ready), 32'h0);
      cyc;
    end
    ld_lock = 1'b0;
    #1;
    chk("unlock_en", 32'(sram_en), 32'h1);
    chk("unlock_addr", 32'(sram_addr), 32'h4);
    cyc;
    chk("unlock_ready", 32'(cpu_ready), 32'h1);
    chk("unlock_rdata", cpu_rdata, 32'hDEAD_AAEF);
    cyc;
    chk("rst_pre_en", 32'(sram_en), 32'h1);
    cyc;
    chk("rst_pre_ready", 32'(cpu_ready), 32'h1);
    resetn = 1'b0;
    cpu_valid = 1'b0;
    #1;
    chk("rst_ready_drop", 32'(cpu_ready), 32'h0);
    chk("rst_rdata_drop", cpu_rdata, 32'h0);
    chk("rst_en", 32'(sram_en), 32'h0);
    cyc;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_zero("post_rst");
      chk("post_rst_state", 32'(dut.st), 32'(ST_IDLE));
      cyc;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
